axi_write_scheduler: RTL and testbench
======================================

Name: axi_write_scheduler

Overview:
- Sequences whole AXI write transactions (AW, then W burst, then B) from two masters: M1 (CPU data) and M2 (DMA).
- Six slaves: S0 ROM, S1 IM, S2 DM, S3 DMA, S4 WDT, S5 DRAM.
- Round-robin arbitration, one outstanding write at a time, address decode to a one-hot slave select.
- An internal default slave completes writes to unmapped addresses with DECERR. Its outputs steer the AW/W/B datapath muxes of the bridge.

Parameters:
- ADDR_W, 32, address width.
- TIMEOUT_CYCLES, 1024, stall limit for the optional timeout (effective range 2..65535).

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-low
- awvalid_m1  in  1  AWVALID from M1
- awaddr_m1  in  ADDR_W  AWADDR from M1
- awvalid_m2  in  1  AWVALID from M2
- awaddr_m2  in  ADDR_W  AWADDR from M2
- awready_sel  in  1  AWREADY of the currently selected slave (muxed externally)
- wvalid  in  1  WVALID of the granted master
- wready_sel  in  1  WREADY of the selected slave
- wlast  in  1  WLAST of the granted master
- bvalid_sel  in  1  BVALID of the selected slave
- bready  in  1  BREADY of the granted master
- grant  out  2  one-hot {M2,M1}
- slave_sel  out  6  one-hot S5..S0
- phase  out  2  0 IDLE, 1 AW, 2 W, 3 B
- dflt_awready  out  1  default-slave AWREADY
- dflt_wready  out  1  default-slave WREADY
- dflt_bvalid  out  1  default-slave BVALID
- dflt_bresp  out  2  default-slave BRESP
- timeout_err  out  1  one-cycle pulse (optional feature)

Behaviour:
- Reset: state IDLE; grant=0, slave_sel=0, phase=0, all dflt_* =0, timeout_err=0; last_grant=M2, so M1 wins the first tie.
- IDLE:
  - If any awvalid_m*: select the requester. When both request, pick the one not equal to last_grant. Register grant and the decoded slave_sel; go to AW on the next edge.
  - Request in cycle N gives grant in cycle N+1.
- Address decode, inclusive ranges:
  - S0 0x0000_0000–0x0000_3FFF
  - S1 0x0001_0000–0x0001_FFFF
  - S2 0x0002_0000–0x0002_FFFF
  - S4 0x1001_0000–0x1001_03FF
  - S3 0x1002_0000–0x1002_03FF
  - S5 0x2000_0000–0x201F_FFFF
  - Otherwise: slave_sel=0 and the decerr flag is registered.
- AW:
  - Exit on granted awvalid & awready_sel, or granted awvalid & dflt_awready when decerr. Go to W.
  - dflt_awready is asserted combinationally in AW when decerr.
  - If the granted master drops awvalid, keep waiting; grant is never revoked.
- W:
  - Exit on wvalid & (wready_sel or dflt_wready) & wlast. Go to B.
  - dflt_wready=1 throughout W when decerr.
  - Single-beat bursts (wlast on the first beat) are legal.
- B:
  - Exit on (bvalid_sel or dflt_bvalid) & bready. Go to IDLE; last_grant updates to the current grant.
  - Clear grant and slave_sel on that same edge. One IDLE cycle is always inserted between transactions.
  - dflt_bvalid=1 and dflt_bresp=2'b11 in B when decerr; dflt_bresp=0 otherwise.
- grant and slave_sel are stable from AW through B. Requests arriving during a transaction are ignored until IDLE.
- Asynchronous reset mid-transaction returns to IDLE immediately with all outputs at reset values.

Optional Feature:
- AXI_WR_TIMEOUT_EN defined:
  - 16-bit stall counter runs in AW/W/B.
  - It clears on every state change and on every W beat handshake.
  - When it reaches TIMEOUT_CYCLES-1: pulse timeout_err for one cycle, force IDLE, clear grant/slave_sel, leave last_grant unchanged.
- Not defined: no counter; timeout_err tied to 0; the FSM waits indefinitely.

Test Plan:
- M1 writes 0x0002_0010, 4-beat burst, all ready=1 -> grant=01 at cycle+1, slave_sel=000100, phase 1→2→3→0, back to IDLE after bvalid&bready.
- M1 and M2 request in the same cycle after reset -> M1 granted first. Both requesting again -> M2 granted next, then M1 (strict alternation).
- M2 writes 0x3000_0000 -> slave_sel=0, dflt_awready=1 in AW, dflt_wready=1 in W, dflt_bvalid=1 with bresp=11 in B.
- awready_sel=0 for 5 cycles with awvalid held; M2 requests during the wait -> FSM stays in AW, grant stays 01, M2 is served after IDLE.
- Reset asserted while in W -> outputs zero the same cycle; after release, a new M2 request is granted normally.
- With AXI_WR_TIMEOUT_EN and TIMEOUT_CYCLES=8: bvalid_sel held 0 -> timeout_err pulses 8 cycles after entering B, phase returns to 0.

Source files
------------

// File: rtl/axi_write_scheduler.sv
// Write-transaction scheduler for two AXI masters and six slaves, with an internal DECERR default slave.
// Optional stall timeout is built when AXI_WR_TIMEOUT_EN is defined.
module axi_write_scheduler #(
    parameter int ADDR_W         = 32,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              awvalid_m1,
    input  logic [ADDR_W-1:0] awaddr_m1,
    input  logic              awvalid_m2,
    input  logic [ADDR_W-1:0] awaddr_m2,
    input  logic              awready_sel,
    input  logic              wvalid,
    input  logic              wready_sel,
    input  logic              wlast,
    input  logic              bvalid_sel,
    input  logic              bready,
    output logic [1:0]        grant,
    output logic [5:0]        slave_sel,
    output logic [1:0]        phase,
    output logic              dflt_awready,
    output logic              dflt_wready,
    output logic              dflt_bvalid,
    output logic [1:0]        dflt_bresp,
    output logic              timeout_err
);
    // state    | meaning
    // ST_IDLE  | no transaction, arbitrating requests
    // ST_AW    | waiting for the address handshake
    // ST_W     | data burst until the wlast beat is accepted
    // ST_B     | waiting for the write response handshake
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_AW   = 2'd1,
        ST_W    = 2'd2,
        ST_B    = 2'd3
    } state_t;

    state_t      state, state_nxt;
    logic [1:0]  grant_nxt;
    logic [5:0]  sel_nxt;
    logic        decerr, decerr_nxt;
    logic [1:0]  last_grant, last_nxt;
    logic [1:0]  req, pick;
    logic [ADDR_W-1:0] pick_addr;
    logic [6:0]  pick_dec;
    logic        awvalid_g, aw_hs, w_hs, b_hs;
    logic        timeout_hit;

    // Returns {decerr, one-hot slave select}; ranges are inclusive.
    function automatic logic [6:0] decode(input logic [ADDR_W-1:0] addr);
        logic [63:0] a;
        a = 64'(addr);
        if (a <= 64'h0000_3FFF)                              return 7'b0_000001;
        if (a >= 64'h0001_0000 && a <= 64'h0001_FFFF)       return 7'b0_000010;
        if (a >= 64'h0002_0000 && a <= 64'h0002_FFFF)       return 7'b0_000100;
        if (a >= 64'h1002_0000 && a <= 64'h1002_03FF)       return 7'b0_001000;
        if (a >= 64'h1001_0000 && a <= 64'h1001_03FF)       return 7'b0_010000;
        if (a >= 64'h2000_0000 && a <= 64'h201F_FFFF)       return 7'b0_100000;
        return 7'b1_000000;
    endfunction

    assign req       = {awvalid_m2, awvalid_m1};
    assign pick      = (&req) ? (last_grant[0] ? 2'b10 : 2'b01) : req;
    assign pick_addr = pick[1] ? awaddr_m2 : awaddr_m1;
    assign pick_dec  = decode(pick_addr);

    assign phase        = state;
    assign dflt_awready = (state == ST_AW) && decerr;
    assign dflt_wready  = (state == ST_W)  && decerr;
    assign dflt_bvalid  = (state == ST_B)  && decerr;
    assign dflt_bresp   = dflt_bvalid ? 2'b11 : 2'b00;

    assign awvalid_g = (grant[0] & awvalid_m1) | (grant[1] & awvalid_m2);
    assign aw_hs     = awvalid_g & (awready_sel | dflt_awready);
    assign w_hs      = (state == ST_W) & wvalid & (wready_sel | dflt_wready);
    assign b_hs      = (bvalid_sel | dflt_bvalid) & bready;

    always_comb begin
        state_nxt  = state;
        grant_nxt  = grant;
        sel_nxt    = slave_sel;
        decerr_nxt = decerr;
        last_nxt   = last_grant;
        case (state)
            ST_IDLE: begin
                if (|req) begin
                    state_nxt  = ST_AW;
                    grant_nxt  = pick;
                    sel_nxt    = pick_dec[5:0];
                    decerr_nxt = pick_dec[6];
                end
            end
            ST_AW: if (aw_hs) state_nxt = ST_W;
            ST_W:  if (w_hs && wlast) state_nxt = ST_B;
            ST_B: begin
                if (b_hs) begin
                    state_nxt  = ST_IDLE;
                    last_nxt   = grant;
                    grant_nxt  = 2'b00;
                    sel_nxt    = 6'b0;
                    decerr_nxt = 1'b0;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
        // A timeout abandons the transaction without crediting it to the arbiter.
        if (timeout_hit) begin
            state_nxt  = ST_IDLE;
            grant_nxt  = 2'b00;
            sel_nxt    = 6'b0;
            decerr_nxt = 1'b0;
            last_nxt   = last_grant;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= ST_IDLE;
            grant      <= 2'b00;
            slave_sel  <= 6'b0;
            decerr     <= 1'b0;
            last_grant <= 2'b10;
        end else begin
            state      <= state_nxt;
            grant      <= grant_nxt;
            slave_sel  <= sel_nxt;
            decerr     <= decerr_nxt;
            last_grant <= last_nxt;
        end
    end

`ifdef AXI_WR_TIMEOUT_EN
    logic [15:0] stall_cnt;

    assign timeout_hit = (state != ST_IDLE) && (stall_cnt == 16'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cnt   <= 16'd0;
            timeout_err <= 1'b0;
        end else begin
            timeout_err <= timeout_hit;
            if (state == ST_IDLE || state_nxt != state || w_hs)
                stall_cnt <= 16'd0;
            else
                stall_cnt <= stall_cnt + 16'd1;
        end
    end
`else
    assign timeout_hit = 1'b0;
    assign timeout_err = 1'b0;
`endif

endmodule

// File: tb/tb_axi_write_scheduler.sv
// Scoreboard bench for axi_write_scheduler: stimulus queues expected grants, a negedge monitor checks them.
module tb_axi_write_scheduler;
    logic        clk, rst;
    logic        awvalid_m1, awvalid_m2;
    logic [31:0] awaddr_m1, awaddr_m2;
    logic        awready_sel, wvalid, wready_sel, wlast, bvalid_sel, bready;
    logic [1:0]  grant, phase, dflt_bresp;
    logic [5:0]  slave_sel;
    logic        dflt_awready, dflt_wready, dflt_bvalid, timeout_err;

    axi_write_scheduler #(.ADDR_W(32), .TIMEOUT_CYCLES(1024)) dut (
        .clk(clk), .rst(rst),
        .awvalid_m1(awvalid_m1), .awaddr_m1(awaddr_m1),
        .awvalid_m2(awvalid_m2), .awaddr_m2(awaddr_m2),
        .awready_sel(awready_sel), .wvalid(wvalid), .wready_sel(wready_sel),
        .wlast(wlast), .bvalid_sel(bvalid_sel), .bready(bready),
        .grant(grant), .slave_sel(slave_sel), .phase(phase),
        .dflt_awready(dflt_awready), .dflt_wready(dflt_wready),
        .dflt_bvalid(dflt_bvalid), .dflt_bresp(dflt_bresp),
        .timeout_err(timeout_err)
    );

    typedef struct packed {
        logic [1:0] g;
        logic [5:0] sel;
        logic       dec;
    } exp_t;

    exp_t sb[$];
    exp_t cur;
    int   vectors = 0;
    int   miscompares = 0;
    logic [1:0] prev_phase;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: pops one expectation per new grant and checks default-slave outputs each cycle.
    initial begin
        cur = '0;
        prev_phase = 2'd0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                prev_phase = 2'd0;
            end else begin
                if (phase == 2'd1 && prev_phase == 2'd0) begin
                    if (sb.size() == 0) begin
                        vectors++;
                        miscompares++;
                        $display("FAIL unexpected_grant: got grant %0b with empty queue", grant);
                    end else begin
                        cur = sb.pop_front();
                        check("mon_grant", grant, cur.g);
                        check("mon_slave_sel", slave_sel, cur.sel);
                    end
                end
                if (phase != 2'd0) begin
                    check("mon_grant_hold", grant, cur.g);
                    check("mon_dflt_awready", dflt_awready, phase == 2'd1 && cur.dec);
                    check("mon_dflt_wready", dflt_wready, phase == 2'd2 && cur.dec);
                    check("mon_dflt_bvalid", dflt_bvalid, phase == 2'd3 && cur.dec);
                end else begin
                    check("mon_idle_grant", grant, 0);
                end
                check("mon_timeout_err", timeout_err, 0);
                prev_phase = phase;
            end
        end
    end

    // Drives one full transaction for master m whose awvalid is already up in an IDLE cycle.
    task automatic serve(input int m, input logic [5:0] sel, input logic dec,
                         input int beats, input int aw_stall, input bit raise_other);
        exp_t e;
        e.g = (m == 1) ? 2'b01 : 2'b10;
        e.sel = sel;
        e.dec = dec;
        sb.push_back(e);
        @(posedge clk); #1;
        check("grant_latency", grant, e.g);
        check("phase_aw", phase, 1);
        for (int i = 0; i < aw_stall; i++) begin
            if (raise_other && i == 1) begin
                if (m == 1) awvalid_m2 = 1'b1; else awvalid_m1 = 1'b1;
            end
            @(posedge clk); #1;
            check("aw_wait_phase", phase, 1);
            check("aw_wait_grant", grant, e.g);
        end
        if (!dec) awready_sel = 1'b1;
        @(posedge clk); #1;
        awready_sel = 1'b0;
        if (m == 1) awvalid_m1 = 1'b0; else awvalid_m2 = 1'b0;
        check("phase_w", phase, 2);
        wvalid = 1'b1;
        if (!dec) wready_sel = 1'b1;
        for (int b = 0; b < beats; b++) begin
            wlast = (b == beats - 1);
            @(posedge clk); #1;
            check("w_beat_phase", phase, (b == beats - 1) ? 3 : 2);
        end
        wvalid = 1'b0;
        wlast = 1'b0;
        wready_sel = 1'b0;
        if (!dec) bvalid_sel = 1'b1;
        bready = 1'b1;
        check("b_bresp", dflt_bresp, dec ? 3 : 0);
        @(posedge clk); #1;
        bvalid_sel = 1'b0;
        bready = 1'b0;
        check("phase_idle", phase, 0);
        check("sel_clear", slave_sel, 0);
    endtask

    typedef struct {
        logic [31:0] addr;
        logic [5:0]  sel;
        logic        dec;
    } dec_vec_t;

    dec_vec_t dec_tab[10];

    initial begin
        dec_tab[0] = '{32'h0000_3FFF, 6'b000001, 1'b0};
        dec_tab[1] = '{32'h0000_4000, 6'b000000, 1'b1};
        dec_tab[2] = '{32'h0001_FFFF, 6'b000010, 1'b0};
        dec_tab[3] = '{32'h0002_0000, 6'b000100, 1'b0};
        dec_tab[4] = '{32'h1001_03FF, 6'b010000, 1'b0};
        dec_tab[5] = '{32'h1001_0400, 6'b000000, 1'b1};
        dec_tab[6] = '{32'h1002_0000, 6'b001000, 1'b0};
        dec_tab[7] = '{32'h201F_FFFF, 6'b100000, 1'b0};
        dec_tab[8] = '{32'h2020_0000, 6'b000000, 1'b1};
        dec_tab[9] = '{32'hFFFF_FFFF, 6'b000000, 1'b1};

        rst = 1'b0;
        awvalid_m1 = 1'b0; awvalid_m2 = 1'b0;
        awaddr_m1 = '0; awaddr_m2 = '0;
        awready_sel = 1'b0; wvalid = 1'b0; wready_sel = 1'b0; wlast = 1'b0;
        bvalid_sel = 1'b0; bready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_grant", grant, 0);
        check("rst_slave_sel", slave_sel, 0);
        check("rst_phase", phase, 0);
        check("rst_dflt", {dflt_awready, dflt_wready, dflt_bvalid, dflt_bresp}, 0);
        check("rst_timeout_err", timeout_err, 0);
        rst = 1'b1;

        // Simultaneous requests: M1 first, then strict alternation.
        awaddr_m1 = 32'h0002_0000;
        awaddr_m2 = 32'h2000_0000;
        awvalid_m1 = 1'b1; awvalid_m2 = 1'b1;
        serve(1, 6'b000100, 1'b0, 1, 0, 0);
        awvalid_m1 = 1'b1;
        serve(2, 6'b100000, 1'b0, 2, 0, 0);
        serve(1, 6'b000100, 1'b0, 1, 0, 0);
        awvalid_m1 = 1'b1; awvalid_m2 = 1'b1;
        serve(2, 6'b100000, 1'b0, 1, 0, 0);
        serve(1, 6'b000100, 1'b0, 1, 0, 0);

        // M1 4-beat write to DM.
        awaddr_m1 = 32'h0002_0010;
        awvalid_m1 = 1'b1;
        serve(1, 6'b000100, 1'b0, 4, 0, 0);

        // M2 unmapped write completes through the default slave.
        awaddr_m2 = 32'h3000_0000;
        awvalid_m2 = 1'b1;
        serve(2, 6'b000000, 1'b1, 2, 0, 0);

        // AW stall with a competing M2 request arriving mid-wait.
        awaddr_m1 = 32'h0000_0100;
        awaddr_m2 = 32'h2000_0040;
        awvalid_m1 = 1'b1;
        serve(1, 6'b000001, 1'b0, 1, 5, 1);
        serve(2, 6'b100000, 1'b0, 1, 0, 0);

        // Decode boundaries.
        for (int i = 0; i < 10; i++) begin
            awaddr_m1 = dec_tab[i].addr;
            awvalid_m1 = 1'b1;
            serve(1, dec_tab[i].sel, dec_tab[i].dec, 1, 0, 0);
        end

        // Asynchronous reset during W.
        awaddr_m1 = 32'h0000_4000;
        awvalid_m1 = 1'b1;
        sb.push_back('{2'b01, 6'b000000, 1'b1});
        @(posedge clk); #1;
        check("rst_test_grant", grant, 2'b01);
        @(posedge clk); #1;
        awvalid_m1 = 1'b0;
        check("rst_test_phase_w", phase, 2);
        check("rst_test_dflt_wready", dflt_wready, 1);
        wvalid = 1'b1;
        #2;
        rst = 1'b0;
        #1;
        check("async_rst_phase", phase, 0);
        check("async_rst_grant", grant, 0);
        check("async_rst_dflt_wready", dflt_wready, 0);
        wvalid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        awaddr_m2 = 32'h1002_03FF;
        awvalid_m2 = 1'b1;
        serve(2, 6'b001000, 1'b0, 2, 0, 0);

        repeat (2) @(posedge clk);
        #1;
        check("queue_drained", sb.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
